pipe_ctrl: RTL and testbench

- Central pipeline controller for the milano RV32 core.
- Sequences the boot after reset and drives PC redirects into if_stage.
- Generates stall and flush controls for the IF/ID and ID/EX pipeline registers: load-use bubbles, taken-branch flushes, and freezes during multicycle EX operations.
- Keeps a free-running stall-cycle counter for debug.

---
 rtl/pipe_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the milano RV32 core.
// Boot sequencing after reset, PC redirects into if_stage, stall/flush
// generation for the IF/ID and ID/EX registers, and a debug stall counter.
//
// Handshake/timing contract: all outputs are combinational decodes of the
// registered controller state and the current-cycle pipeline inputs; the
// consumer stages act on them at the next rising clk_i edge.
module pipe_ctrl #(
    parameter int BOOT_DELAY = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] boot_addr_i,
    input  logic            id_valid_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic            ex_valid_i,
    input  logic            ex_we_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic            ex_branch_taken_i,
    input  logic [XLEN-1:0] ex_branch_target_i,
    input  logic            ex_mc_start_i,
    input  logic            ex_mc_done_i,
    output logic            fetch_en_o,
    output logic            pc_set_o,
    output logic [XLEN-1:0] pc_target_o,
    output logic            stall_if_o,
    output logic            stall_id_o,
    output logic            stall_ex_o,
    output logic            flush_id_o,
    output logic            flush_ex_o,
    output logic [1:0]      ctrl_state_o,
    output logic [31:0]     stall_cnt_o
);

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        BOOT       = 2'd1,
        RUN        = 2'd2,
        MC_WAIT    = 2'd3
    } state_e;

    // A BOOT_DELAY of 1 still needs a 1-bit counter that simply sits at zero.
    localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(BOOT_DELAY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic branch_take;
    logic mc_start;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    // Hazard and event decodes shared by the state machine below.
    always_comb begin
        branch_take = ex_valid_i & ex_branch_taken_i;
        mc_start    = ex_valid_i & ex_mc_start_i;
        rs1_hit     = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit     = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
        // x0 is never a real producer, so rd=0 can never create a hazard.
        load_use    = ex_valid_i & ex_is_load_i & ex_we_i &
                      (ex_rd_addr_i != 5'd0) & id_valid_i & (rs1_hit | rs2_hit);
    end

    // Output decode and next-state logic; RUN applies branch > mc > load-use.
    always_comb begin
        state_d     = state_q;
        dly_cnt_d   = dly_cnt_q;
        stall_cnt_d = stall_cnt_q;
        fetch_en_o  = 1'b0;
        pc_set_o    = 1'b0;
        pc_target_o = '0;
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        unique case (state_q)
            RESET_WAIT: begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
                if (dly_cnt_q == DLY_LAST) begin
                    state_d = BOOT;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            BOOT: begin
                pc_set_o    = 1'b1;
                pc_target_o = boot_addr_i;
                flush_id_o  = 1'b1;
                flush_ex_o  = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                fetch_en_o = 1'b1;
                if (branch_take) begin
                    pc_set_o    = 1'b1;
                    pc_target_o = ex_branch_target_i;
                    flush_id_o  = 1'b1;
                    flush_ex_o  = 1'b1;
                end else if (mc_start) begin
                    // A same-cycle done means the unit finished instantly.
                    if (!ex_mc_done_i) begin
                        stall_if_o  = 1'b1;
                        stall_id_o  = 1'b1;
                        stall_ex_o  = 1'b1;
                        stall_cnt_d = stall_cnt_q + 32'd1;
                        state_d     = MC_WAIT;
                    end
                end else if (load_use) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    flush_ex_o  = 1'b1;
                    stall_cnt_d = stall_cnt_q + 32'd1;
                end
            end
            MC_WAIT: begin
                // EX is frozen, so branch and hazard inputs are stale here.
                fetch_en_o = 1'b1;
                if (ex_mc_done_i) begin
                    state_d = RUN;
                end else begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    stall_ex_o  = 1'b1;
                    stall_cnt_d = stall_cnt_q + 32'd1;
                end
            end
            default: state_d = RESET_WAIT;
        endcase
    end

    // Controller state, boot delay counter and debug stall counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RESET_WAIT;
            dly_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dly_cnt_q   <= dly_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl_state_o = state_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized
// run compared against a cycle-count based behavioural model.
module tb_pipe_ctrl;

    localparam int BD   = 4;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] boot_addr_i = 32'h0000_0080;
    logic            id_valid_i = 0, id_rs1_used_i = 0, id_rs2_used_i = 0;
    logic [4:0]      id_rs1_addr_i = 0, id_rs2_addr_i = 0, ex_rd_addr_i = 0;
    logic            ex_valid_i = 0, ex_we_i = 0, ex_is_load_i = 0;
    logic            ex_branch_taken_i = 0, ex_mc_start_i = 0, ex_mc_done_i = 0;
    logic [XLEN-1:0] ex_branch_target_i = 0;
    logic            fetch_en_o, pc_set_o, stall_if_o, stall_id_o, stall_ex_o;
    logic            flush_id_o, flush_ex_o;
    logic [XLEN-1:0] pc_target_o;
    logic [1:0]      ctrl_state_o;
    logic [31:0]     stall_cnt_o;

    pipe_ctrl #(.BOOT_DELAY(BD), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_ni(rst_n), .boot_addr_i(boot_addr_i),
        .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i),
        .id_rs2_addr_i(id_rs2_addr_i), .id_rs1_used_i(id_rs1_used_i),
        .id_rs2_used_i(id_rs2_used_i), .ex_valid_i(ex_valid_i), .ex_we_i(ex_we_i),
        .ex_is_load_i(ex_is_load_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_branch_taken_i(ex_branch_taken_i), .ex_branch_target_i(ex_branch_target_i),
        .ex_mc_start_i(ex_mc_start_i), .ex_mc_done_i(ex_mc_done_i),
        .fetch_en_o(fetch_en_o), .pc_set_o(pc_set_o), .pc_target_o(pc_target_o),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
        .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
        .ctrl_state_o(ctrl_state_o), .stall_cnt_o(stall_cnt_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: cycles elapsed since reset release, whether a multicycle op is
    // outstanding, and the expected stall count.
    int          ncyc = 0;
    bit          in_mc = 0;
    logic [31:0] exp_cnt = 0;

    typedef struct packed {
        logic            fetch;
        logic            pc_set;
        logic [XLEN-1:0] tgt;
        logic            sif, sid, sex, fid, fex;
        logic [1:0]      st;
    } exp_t;

    function automatic exp_t model_eval();
        exp_t e;
        bit br, mcs, lu;
        e   = '0;
        br  = ex_valid_i && ex_branch_taken_i;
        mcs = ex_valid_i && ex_mc_start_i;
        lu  = ex_valid_i && ex_is_load_i && ex_we_i && (ex_rd_addr_i != 0) && id_valid_i &&
              ((id_rs1_used_i && id_rs1_addr_i == ex_rd_addr_i) ||
               (id_rs2_used_i && id_rs2_addr_i == ex_rd_addr_i));
        if (!rst_n || ncyc < BD) begin
            e.sif = 1; e.sid = 1; e.st = 2'd0;
        end else if (ncyc == BD) begin
            e.st = 2'd1; e.pc_set = 1; e.tgt = boot_addr_i; e.fid = 1; e.fex = 1;
        end else if (in_mc) begin
            e.st = 2'd3; e.fetch = 1;
            if (!ex_mc_done_i) begin e.sif = 1; e.sid = 1; e.sex = 1; end
        end else begin
            e.st = 2'd2; e.fetch = 1;
            if (br) begin
                e.pc_set = 1; e.tgt = ex_branch_target_i; e.fid = 1; e.fex = 1;
            end else if (mcs) begin
                if (!ex_mc_done_i) begin e.sif = 1; e.sid = 1; e.sex = 1; end
            end else if (lu) begin
                e.sif = 1; e.sid = 1; e.fex = 1;
            end
        end
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.fetch = fetch_en_o; a.pc_set = pc_set_o; a.tgt = pc_target_o;
        a.sif = stall_if_o; a.sid = stall_id_o; a.sex = stall_ex_o;
        a.fid = flush_id_o; a.fex = flush_ex_o; a.st = ctrl_state_o;
        return a;
    endfunction

    function automatic void model_reset();
        ncyc = 0; in_mc = 0; exp_cnt = 0;
    endfunction

    // Advance one clock and update the model with this cycle's inputs.
    task automatic advance();
        exp_t e;
        bit nxt_mc;
        e = model_eval();
        nxt_mc = in_mc;
        if (ncyc > BD) begin
            if (in_mc) nxt_mc = !ex_mc_done_i;
            else nxt_mc = !(ex_valid_i && ex_branch_taken_i) &&
                          (ex_valid_i && ex_mc_start_i) && !ex_mc_done_i;
        end
        @(posedge clk);
        if (ncyc > BD && e.sif) exp_cnt = exp_cnt + 32'd1;
        in_mc = nxt_mc;
        ncyc++;
        #1;
    endtask

    task automatic idle_inputs();
        id_valid_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
        id_rs1_addr_i = 0; id_rs2_addr_i = 0; ex_rd_addr_i = 0;
        ex_valid_i = 0; ex_we_i = 0; ex_is_load_i = 0;
        ex_branch_taken_i = 0; ex_mc_start_i = 0; ex_mc_done_i = 0;
        ex_branch_target_i = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic rs1u);
        ex_valid_i = 1; ex_we_i = 1; ex_is_load_i = 1; ex_rd_addr_i = rd;
        id_valid_i = 1; id_rs1_addr_i = 5'd5; id_rs1_used_i = rs1u;
        id_rs2_addr_i = 5'd7; id_rs2_used_i = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        boot_addr_i = 32'h0000_0080;
        @(posedge clk); #1;
        model_reset();
        total++;
        if ({fetch_en_o, pc_set_o, stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o} !== 7'b0011000) begin
            bad++; $display("FAIL reset_ctl got %b want 0011000",
                {fetch_en_o, pc_set_o, stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o});
        end
        total++;
        if (pc_target_o !== 32'h0 || ctrl_state_o !== 2'd0 || stall_cnt_o !== 32'h0) begin
            bad++; $display("FAIL reset_vals got tgt=%h st=%0d cnt=%0d want 0 0 0",
                pc_target_o, ctrl_state_o, stall_cnt_o);
        end
        rst_n = 1'b1;
        for (int i = 0; i < BD; i++) begin
            #2;
            total++;
            if (ctrl_state_o !== 2'd0 || stall_if_o !== 1'b1 || fetch_en_o !== 1'b0) begin
                bad++; $display("FAIL reset_wait cyc=%0d got st=%0d sif=%b fe=%b want 0 1 0",
                    i, ctrl_state_o, stall_if_o, fetch_en_o);
            end
            advance();
        end
        #2;
        total++;
        if (ctrl_state_o !== 2'd1 || pc_set_o !== 1'b1 || pc_target_o !== 32'h80 ||
            flush_id_o !== 1'b1 || flush_ex_o !== 1'b1 || stall_if_o !== 1'b0 || fetch_en_o !== 1'b0) begin
            bad++; $display("FAIL boot_cycle got st=%0d ps=%b tgt=%h fid=%b fex=%b sif=%b fe=%b want 1 1 80 1 1 0 0",
                ctrl_state_o, pc_set_o, pc_target_o, flush_id_o, flush_ex_o, stall_if_o, fetch_en_o);
        end
        advance();
        #2;
        total++;
        if (ctrl_state_o !== 2'd2 || fetch_en_o !== 1'b1 || pc_set_o !== 1'b0 || pc_target_o !== 32'h0) begin
            bad++; $display("FAIL run_entry got st=%0d fe=%b ps=%b tgt=%h want 2 1 0 0",
                ctrl_state_o, fetch_en_o, pc_set_o, pc_target_o);
        end
        advance();
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        c0 = stall_cnt_o;
        set_load_use(5'd5, 1'b1);
        #2;
        total++;
        if ({stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o, pc_set_o} !== 6'b110010) begin
            bad++; $display("FAIL load_use got %b want 110010",
                {stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o, pc_set_o});
        end
        advance();
        idle_inputs();
        #2;
        total++;
        if (stall_cnt_o !== c0 + 32'd1 || stall_if_o !== 1'b0 || ctrl_state_o !== 2'd2) begin
            bad++; $display("FAIL load_use_after got cnt=%0d sif=%b st=%0d want %0d 0 2",
                stall_cnt_o, stall_if_o, ctrl_state_o, c0 + 32'd1);
        end
        advance();
        // rd = x0: never a hazard
        set_load_use(5'd0, 1'b1);
        id_rs1_addr_i = 5'd0;
        #2;
        total++;
        if (stall_if_o !== 1'b0 || flush_ex_o !== 1'b0) begin
            bad++; $display("FAIL load_use_x0 got sif=%b fex=%b want 0 0", stall_if_o, flush_ex_o);
        end
        advance();
        // rs1 matches but is not used
        set_load_use(5'd5, 1'b0);
        #2;
        total++;
        if (stall_if_o !== 1'b0 || flush_ex_o !== 1'b0) begin
            bad++; $display("FAIL load_use_unused got sif=%b fex=%b want 0 0", stall_if_o, flush_ex_o);
        end
        advance();
        // matching hazard but ID slot empty
        set_load_use(5'd5, 1'b1);
        id_valid_i = 0;
        #2;
        total++;
        if (stall_if_o !== 1'b0 || flush_ex_o !== 1'b0) begin
            bad++; $display("FAIL load_use_idinv got sif=%b fex=%b want 0 0", stall_if_o, flush_ex_o);
        end
        advance();
        // rs2 match path
        set_load_use(5'd7, 1'b1);
        #2;
        total++;
        if (stall_if_o !== 1'b1 || stall_id_o !== 1'b1 || flush_ex_o !== 1'b1) begin
            bad++; $display("FAIL load_use_rs2 got sif=%b sid=%b fex=%b want 1 1 1",
                stall_if_o, stall_id_o, flush_ex_o);
        end
        advance();
        idle_inputs();
        #2;
        total++;
        if (stall_cnt_o !== c0 + 32'd2) begin
            bad++; $display("FAIL load_use_cnt got %0d want %0d", stall_cnt_o, c0 + 32'd2);
        end
        advance();
    endtask

    task automatic test_branch_hazard();
        set_load_use(5'd5, 1'b1);
        ex_mc_start_i = 1;
        ex_branch_taken_i = 1;
        ex_branch_target_i = 32'h0000_0200;
        #2;
        total++;
        if (pc_set_o !== 1'b1 || pc_target_o !== 32'h200 || flush_id_o !== 1'b1 || flush_ex_o !== 1'b1 ||
            stall_if_o !== 1'b0 || stall_id_o !== 1'b0 || stall_ex_o !== 1'b0) begin
            bad++; $display("FAIL branch_prio got ps=%b tgt=%h fid=%b fex=%b s=%b%b%b want 1 200 1 1 000",
                pc_set_o, pc_target_o, flush_id_o, flush_ex_o, stall_if_o, stall_id_o, stall_ex_o);
        end
        advance();
        idle_inputs();
        #2;
        total++;
        if (ctrl_state_o !== 2'd2) begin
            bad++; $display("FAIL branch_state got %0d want 2", ctrl_state_o);
        end
        advance();
    endtask

    task automatic test_multicycle();
        logic [31:0] c0;
        c0 = stall_cnt_o;
        ex_valid_i = 1; ex_mc_start_i = 1;
        #2;
        total++;
        if ({stall_if_o, stall_id_o, stall_ex_o} !== 3'b111 || ctrl_state_o !== 2'd2) begin
            bad++; $display("FAIL mc_start got s=%b st=%0d want 111 2",
                {stall_if_o, stall_id_o, stall_ex_o}, ctrl_state_o);
        end
        advance();
        idle_inputs();
        ex_valid_i = 1; ex_branch_taken_i = 1; ex_branch_target_i = 32'h300;
        #2;
        total++;
        if (ctrl_state_o !== 2'd3 || {stall_if_o, stall_id_o, stall_ex_o} !== 3'b111 ||
            pc_set_o !== 1'b0 || flush_id_o !== 1'b0 || flush_ex_o !== 1'b0 || fetch_en_o !== 1'b1) begin
            bad++; $display("FAIL mc_wait_branch got st=%0d s=%b ps=%b fid=%b fex=%b fe=%b want 3 111 0 0 0 1",
                ctrl_state_o, {stall_if_o, stall_id_o, stall_ex_o}, pc_set_o, flush_id_o, flush_ex_o, fetch_en_o);
        end
        advance();
        idle_inputs();
        #2;
        total++;
        if (ctrl_state_o !== 2'd3 || {stall_if_o, stall_id_o, stall_ex_o} !== 3'b111) begin
            bad++; $display("FAIL mc_wait2 got st=%0d s=%b want 3 111",
                ctrl_state_o, {stall_if_o, stall_id_o, stall_ex_o});
        end
        advance();
        ex_mc_done_i = 1;
        #2;
        total++;
        if (ctrl_state_o !== 2'd3 || {stall_if_o, stall_id_o, stall_ex_o} !== 3'b000) begin
            bad++; $display("FAIL mc_done got st=%0d s=%b want 3 000",
                ctrl_state_o, {stall_if_o, stall_id_o, stall_ex_o});
        end
        advance();
        idle_inputs();
        #2;
        total++;
        if (ctrl_state_o !== 2'd2 || stall_cnt_o !== c0 + 32'd3) begin
            bad++; $display("FAIL mc_after got st=%0d cnt=%0d want 2 %0d",
                ctrl_state_o, stall_cnt_o, c0 + 32'd3);
        end
        advance();
    endtask

    task automatic test_mc_same_cycle();
        logic [31:0] c0;
        c0 = stall_cnt_o;
        ex_valid_i = 1; ex_mc_start_i = 1; ex_mc_done_i = 1;
        #2;
        total++;
        if ({stall_if_o, stall_id_o, stall_ex_o} !== 3'b000) begin
            bad++; $display("FAIL mc_same got s=%b want 000", {stall_if_o, stall_id_o, stall_ex_o});
        end
        advance();
        idle_inputs();
        #2;
        total++;
        if (ctrl_state_o !== 2'd2 || stall_cnt_o !== c0) begin
            bad++; $display("FAIL mc_same_after got st=%0d cnt=%0d want 2 %0d", ctrl_state_o, stall_cnt_o, c0);
        end
        advance();
    endtask

    task automatic test_reset_mid_mc();
        ex_valid_i = 1; ex_mc_start_i = 1;
        #2;
        advance();
        idle_inputs();
        #2;
        total++;
        if (ctrl_state_o !== 2'd3) begin
            bad++; $display("FAIL pre_reset_state got %0d want 3", ctrl_state_o);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (ctrl_state_o !== 2'd0 || stall_cnt_o !== 32'd0 || stall_if_o !== 1'b1 || fetch_en_o !== 1'b0) begin
            bad++; $display("FAIL async_reset got st=%0d cnt=%0d sif=%b fe=%b want 0 0 1 0",
                ctrl_state_o, stall_cnt_o, stall_if_o, fetch_en_o);
        end
        @(posedge clk); #1;
        boot_addr_i = 32'h0000_1000;
        rst_n = 1'b1;
        for (int i = 0; i < BD; i++) begin
            #2;
            total++;
            if (ctrl_state_o !== 2'd0) begin
                bad++; $display("FAIL reboot_wait cyc=%0d got %0d want 0", i, ctrl_state_o);
            end
            advance();
        end
        #2;
        total++;
        if (ctrl_state_o !== 2'd1 || pc_set_o !== 1'b1 || pc_target_o !== 32'h1000) begin
            bad++; $display("FAIL reboot_boot got st=%0d ps=%b tgt=%h want 1 1 1000",
                ctrl_state_o, pc_set_o, pc_target_o);
        end
        advance();
    endtask

    task automatic test_random();
        exp_t e;
        exp_t a;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        boot_addr_i = $urandom;
        for (int i = 0; i < 400; i++) begin
            id_valid_i         = ($urandom_range(0, 3) != 0);
            id_rs1_addr_i      = 5'($urandom_range(0, 3));
            id_rs2_addr_i      = 5'($urandom_range(0, 3));
            id_rs1_used_i      = $urandom_range(0, 1);
            id_rs2_used_i      = $urandom_range(0, 1);
            ex_valid_i         = ($urandom_range(0, 3) != 0);
            ex_we_i            = ($urandom_range(0, 3) != 0);
            ex_is_load_i       = $urandom_range(0, 1);
            ex_rd_addr_i       = 5'($urandom_range(0, 3));
            ex_branch_taken_i  = ($urandom_range(0, 5) == 0);
            ex_branch_target_i = $urandom;
            ex_mc_start_i      = ($urandom_range(0, 5) == 0);
            ex_mc_done_i       = ($urandom_range(0, 2) == 0);
            #2;
            e = model_eval();
            a = actual();
            total++;
            if (a !== e) begin
                bad++; $display("FAIL rand_outs cyc=%0d got %h want %h", i, a, e);
            end
            total++;
            if (stall_cnt_o !== exp_cnt) begin
                bad++; $display("FAIL rand_cnt cyc=%0d got %0d want %0d", i, stall_cnt_o, exp_cnt);
            end
            advance();
        end
        idle_inputs();
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_multicycle();
        test_mc_same_cycle();
        test_reset_mid_mc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
